// File: rtl/delay_pipe_pkg.sv
// Shared constants and helpers for the delay_pipe elastic delay line.
package delay_pipe_pkg;

  // Backpressure modes selectable through the MODE parameter.
  localparam int unsigned DELAY_MODE_LOCKSTEP = 0;
  localparam int unsigned DELAY_MODE_COLLAPSE = 1;

  // Width of an occupancy counter that must represent 0..latency inclusive.
  function automatic int unsigned count_width(input int unsigned latency);
    return $clog2(latency + 1);
  endfunction

endpackage

// File: rtl/delay_pipe_stage.sv
// One stage of the delay line: a valid bit plus a payload register.
// The payload only loads when a valid token arrives, so bubbles do not toggle it.
module delay_pipe_stage #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  valid_prev,
  input  logic [DATA_WIDTH-1:0] data_prev,
  output logic                  valid,
  output logic [DATA_WIDTH-1:0] data
);

  logic                  valid_q;
  logic [DATA_WIDTH-1:0] data_q;

  // Stage register: reset wins, otherwise advance on en with load-gated data.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (en) begin
      valid_q <= valid_prev;
      if (valid_prev) begin
        data_q <= data_prev;
      end
    end
  end

  assign valid = valid_q;
  assign data  = data_q;

endmodule

// File: rtl/delay_pipe.sv
// Elastic fixed-latency delay line carrying a payload beside its valid token.
// MODE selects lockstep stalling (whole line freezes on !ready_in) or collapse
// (empty stages keep advancing so bubbles are squeezed out). Also reports how
// many stages currently hold a token.
module delay_pipe
  import delay_pipe_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned LATENCY    = 4,
  parameter int unsigned MODE       = 0
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [DATA_WIDTH-1:0]            data_in,
  input  logic                             valid_in,
  output logic                             ready_out,
  output logic [DATA_WIDTH-1:0]            data_out,
  output logic                             valid_out,
  input  logic                             ready_in,
  output logic [count_width(LATENCY)-1:0]  count
);

  localparam int unsigned CountWidth = count_width(LATENCY);

  // Reject nonsensical configurations at elaboration time.
  if (DATA_WIDTH < 1) begin : g_bad_width
    $error("delay_pipe: DATA_WIDTH must be at least 1");
  end
  if (LATENCY < 1) begin : g_bad_latency
    $error("delay_pipe: LATENCY must be at least 1");
  end
  if (MODE != DELAY_MODE_LOCKSTEP && MODE != DELAY_MODE_COLLAPSE) begin : g_bad_mode
    $error("delay_pipe: MODE must be 0 (lockstep) or 1 (collapse)");
  end

  logic [LATENCY-1:0]    v;
  logic [DATA_WIDTH-1:0] d [LATENCY];
  logic [LATENCY-1:0]    en;
  logic                  en_acc;

  logic                  accept_in;
  logic                  transfer_out;
  logic [CountWidth-1:0] count_d, count_q;

  // Stage enables. In collapse mode en[i] = en[i+1] | ~v[i], unrolled from the
  // tail with a running OR so no bit of en feeds back into the same vector.
  always_comb begin
    en     = '0;
    en_acc = ready_in;
    if (MODE == DELAY_MODE_COLLAPSE) begin
      for (int i = int'(LATENCY) - 1; i >= 0; i--) begin
        en_acc = en_acc | ~v[i];
        en[i]  = en_acc;
      end
    end else begin
      en = {LATENCY{ready_in}};
    end
  end

  assign ready_out = en[0];

  for (genvar i = 0; i < LATENCY; i++) begin : g_stage
    logic                  valid_prev;
    logic [DATA_WIDTH-1:0] data_prev;

    if (i == 0) begin : g_head
      assign valid_prev = valid_in;
      assign data_prev  = data_in;
    end else begin : g_body
      assign valid_prev = v[i-1];
      assign data_prev  = d[i-1];
    end

    delay_pipe_stage #(
      .DATA_WIDTH(DATA_WIDTH)
    ) u_stage (
      .clk       (clk),
      .rst       (rst),
      .en        (en[i]),
      .valid_prev(valid_prev),
      .data_prev (data_prev),
      .valid     (v[i]),
      .data      (d[i])
    );
  end

  assign valid_out = v[LATENCY-1];
  assign data_out  = d[LATENCY-1];

  assign accept_in    = valid_in & ready_out;
  assign transfer_out = valid_out & ready_in;

  // Occupancy: +1 per accepted token, -1 per token leaving; both cancel out.
  always_comb begin
    count_d = count_q;
    if (accept_in && !transfer_out) begin
      count_d = count_q + CountWidth'(1);
    end else if (!accept_in && transfer_out) begin
      count_d = count_q - CountWidth'(1);
    end
  end

  // Occupancy register.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: tb/tb_delay_pipe.sv
// Directed bench for delay_pipe: one lockstep and one collapse instance
// (DATA_WIDTH=8, LATENCY=4) sharing clock and reset.
module tb_delay_pipe;

  localparam int unsigned DW = 8;
  localparam int unsigned LAT = 4;

  logic          clk;
  logic          rst;

  logic [DW-1:0] l_data_in, l_data_out;
  logic          l_valid_in, l_ready_out, l_valid_out, l_ready_in;
  logic [2:0]    l_count;

  logic [DW-1:0] c_data_in, c_data_out;
  logic          c_valid_in, c_ready_out, c_valid_out, c_ready_in;
  logic [2:0]    c_count;

  int n_tests = 0;
  int n_fail  = 0;

  delay_pipe #(.DATA_WIDTH(DW), .LATENCY(LAT), .MODE(0)) u_lock (
    .clk      (clk),
    .rst      (rst),
    .data_in  (l_data_in),
    .valid_in (l_valid_in),
    .ready_out(l_ready_out),
    .data_out (l_data_out),
    .valid_out(l_valid_out),
    .ready_in (l_ready_in),
    .count    (l_count)
  );

  delay_pipe #(.DATA_WIDTH(DW), .LATENCY(LAT), .MODE(1)) u_coll (
    .clk      (clk),
    .rst      (rst),
    .data_in  (c_data_in),
    .valid_in (c_valid_in),
    .ready_out(c_ready_out),
    .data_out (c_data_out),
    .valid_out(c_valid_out),
    .ready_in (c_ready_in),
    .count    (c_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance to just after the next rising edge (start of the next cycle).
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    l_valid_in = 1'b0; l_data_in = '0; l_ready_in = 1'b1;
    c_valid_in = 1'b0; c_data_in = '0; c_ready_in = 1'b1;
  endtask

  // Leaves the bench at the start of the first cycle after reset (cycle 0).
  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    next_cycle();
    next_cycle();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    do_reset();

    // Reset state of both instances.
    l_ready_in = 1'b0;
    c_ready_in = 1'b0;
    #2;
    check("rst_l_valid", 32'(l_valid_out), 32'd0);
    check("rst_l_data", 32'(l_data_out), 32'd0);
    check("rst_l_count", 32'(l_count), 32'd0);
    check("rst_l_ready_lo", 32'(l_ready_out), 32'd0);
    check("rst_c_valid", 32'(c_valid_out), 32'd0);
    check("rst_c_count", 32'(c_count), 32'd0);
    check("rst_c_ready", 32'(c_ready_out), 32'd1);
    l_ready_in = 1'b1;
    #1;
    check("rst_l_ready_hi", 32'(l_ready_out), 32'd1);

    // 1: single token through the lockstep line.
    do_reset();
    for (int c = 0; c <= 5; c++) begin
      l_ready_in = 1'b1;
      l_valid_in = (c == 0);
      l_data_in  = (c == 0) ? 8'hA5 : 8'h00;
      #2;
      check($sformatf("t1_valid_c%0d", c), 32'(l_valid_out), 32'(c == 4));
      if (c == 4) check("t1_data_c4", 32'(l_data_out), 32'hA5);
      check($sformatf("t1_count_c%0d", c), 32'(l_count), 32'((c >= 1 && c <= 4) ? 1 : 0));
      next_cycle();
    end

    // 2: lockstep stall cycles 2-4 delay the token to cycle 7.
    do_reset();
    for (int c = 0; c <= 8; c++) begin
      l_ready_in = !(c >= 2 && c <= 4);
      l_valid_in = (c == 0) || (c >= 2 && c <= 4);
      l_data_in  = (c == 0) ? 8'h3C : 8'hEE;
      #2;
      check($sformatf("t2_ready_c%0d", c), 32'(l_ready_out), 32'(!(c >= 2 && c <= 4)));
      check($sformatf("t2_valid_c%0d", c), 32'(l_valid_out), 32'(c == 7));
      if (c == 7) check("t2_data_c7", 32'(l_data_out), 32'h3C);
      if (c == 8) check("t2_count_c8", 32'(l_count), 32'd0);
      next_cycle();
    end

    // 3: collapse line fills against ready_in=0; 0x55 is held off.
    do_reset();
    for (int c = 0; c <= 5; c++) begin
      c_ready_in = 1'b0;
      c_valid_in = 1'b1;
      c_data_in  = (c <= 4) ? 8'(8'h11 * (c + 1)) : 8'h55;
      #2;
      check($sformatf("t3_ready_c%0d", c), 32'(c_ready_out), 32'(c < 4));
      check($sformatf("t3_count_c%0d", c), 32'(c_count), 32'((c < 4) ? c : 4));
      check($sformatf("t3_valid_c%0d", c), 32'(c_valid_out), 32'(c >= 4));
      if (c >= 4) check($sformatf("t3_data_c%0d", c), 32'(c_data_out), 32'h11);
      next_cycle();
    end

    // 4: full line with ready_in=1 takes one in and lets one out.
    c_ready_in = 1'b1; c_valid_in = 1'b1; c_data_in = 8'h66;
    #2;
    check("t4_ready_full", 32'(c_ready_out), 32'd1);
    check("t4_data_out", 32'(c_data_out), 32'h11);
    check("t4_count", 32'(c_count), 32'd4);
    next_cycle();
    c_ready_in = 1'b0; c_valid_in = 1'b0;
    #2;
    check("t4_data_next", 32'(c_data_out), 32'h22);
    check("t4_count_next", 32'(c_count), 32'd4);
    check("t4_ready_next", 32'(c_ready_out), 32'd0);
    next_cycle();
    // Drain: 0x22, 0x33, 0x44, 0x66, then empty with data_out held.
    for (int c = 0; c <= 4; c++) begin
      logic [7:0] exp_d [5];
      exp_d[0] = 8'h22; exp_d[1] = 8'h33; exp_d[2] = 8'h44; exp_d[3] = 8'h66; exp_d[4] = 8'h66;
      c_ready_in = 1'b1;
      #2;
      check($sformatf("t4_drain_valid%0d", c), 32'(c_valid_out), 32'(c < 4));
      check($sformatf("t4_drain_data%0d", c), 32'(c_data_out), 32'(exp_d[c]));
      check($sformatf("t4_drain_count%0d", c), 32'(c_count), 32'(4 - c));
      next_cycle();
    end

    // 5: mid-flight reset flushes both lines.
    do_reset();
    for (int c = 0; c <= 2; c++) begin
      l_valid_in = 1'b1; l_data_in = 8'(8'h81 + c);
      c_valid_in = 1'b1; c_data_in = 8'(8'h81 + c);
      next_cycle();
    end
    l_data_in = 8'h99; c_data_in = 8'h99;
    #2;
    check("t5_l_count_pre", 32'(l_count), 32'd3);
    check("t5_c_count_pre", 32'(c_count), 32'd3);
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    l_valid_in = 1'b0; c_valid_in = 1'b0;
    l_ready_in = 1'b0; c_ready_in = 1'b0;
    #2;
    check("t5_l_valid", 32'(l_valid_out), 32'd0);
    check("t5_l_data", 32'(l_data_out), 32'd0);
    check("t5_l_count", 32'(l_count), 32'd0);
    check("t5_l_ready", 32'(l_ready_out), 32'd0);
    check("t5_c_valid", 32'(c_valid_out), 32'd0);
    check("t5_c_data", 32'(c_data_out), 32'd0);
    check("t5_c_count", 32'(c_count), 32'd0);
    check("t5_c_ready", 32'(c_ready_out), 32'd1);
    next_cycle();
    for (int c = 0; c < 6; c++) begin
      l_ready_in = 1'b1; c_ready_in = 1'b1;
      #2;
      check($sformatf("t5_l_none%0d", c), 32'(l_valid_out), 32'd0);
      check($sformatf("t5_c_none%0d", c), 32'(c_valid_out), 32'd0);
      next_cycle();
    end

    // 6: back-to-back stream through the lockstep line.
    do_reset();
    for (int c = 0; c <= 12; c++) begin
      l_ready_in = 1'b1;
      l_valid_in = (c < 8);
      l_data_in  = 8'(c);
      #2;
      check($sformatf("t6_valid_c%0d", c), 32'(l_valid_out), 32'(c >= 4 && c <= 11));
      if (c >= 4 && c <= 11) check($sformatf("t6_data_c%0d", c), 32'(l_data_out), 32'(c - 4));
      if (c <= 7) check($sformatf("t6_count_c%0d", c), 32'(l_count), 32'((c < 4) ? c : 4));
      next_cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
